ctrl_sequencer: RTL
===================

# ctrl_sequencer

Parametrised, registered successor to the single-cycle decoder in the ID stage. Decodes the 6-bit ISA opcode into execute/memory/writeback controls and sequences multi-cycle macro-ops (two-step SWP and an N-step MUL) with its own step counter. It drives `freeze` to hold fetch/ID for the whole sequence and honours hazard `stall` and branch `flush` from the pipeline.

## Interface
- `OPCODE_W`, default 6: opcode width, must be 6 or more; bits above [5:0] must be zero for a legal opcode.
- `CMD_W`, default 4: `exec_cmd` width, must be 4 or more; the 4-bit codes below are zero-extended.
- `MUL_CYCLES`, default 4: MUL sequence length in steps, 2 to 16.
- `STEP_W`, derived: clog2(max(2, MUL_CYCLES)).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in OPCODE_W: ID-stage opcode, held stable by upstream while `freeze`=1.
- `valid` in 1: opcode is a real instruction.
- `stall` in 1: hazard; hold sequence and emit a bubble.
- `flush` in 1: branch taken; kill the current instruction or sequence.
- `exec_cmd` out CMD_W: ALU command.
- `mem_r_en` out 1, `mem_w_en` out 1, `wb_en` out 1, `is_imm` out 1, `single_src` out 1.
- `branch_type` out 2: 00 none, 01 BEZ, 10 BNE, 11 JMP.
- `swp_sel` out 2: SWP operand select.
- `freeze` out 1: hold PC/IF/ID.
- `busy` out 1: a sequence is in progress (state SEQ).
- `step` out STEP_W: current micro-step index.
- `illegal` out 1: one-cycle pulse when an unknown opcode is decoded.

## Operation
- A bubble means every output is 0, except `freeze`, `busy` and `step`, which follow the state.
- Single-cycle decode (opcode: exec_cmd, then flags):
  - 000000 NOP: 0000, no flags.
  - 000001 ADD: 0000, wb.
  - 000011 SUB: 0010, wb.
  - 000101 AND: 0100, wb.
  - 000110 OR: 0101, wb.
  - 000111 NOR: 0110, wb.
  - 001000 XOR: 0111, wb.
  - 001001 SLA and 001010 SLL: 1000, wb.
  - 001011 SRA: 1001, wb.
  - 001100 SRL: 1010, wb.
  - 100000 ADDI: 0000, imm, wb, single.
  - 100001 SUBI: 0010, imm, wb, single.
  - 100100 LD: 0000, imm, mem_r, wb, single.
  - 100101 ST: 0000, imm, mem_w.
  - 101000 BEZ: 0000, imm, br 01, single.
  - 101001 BNE: 0000, imm, br 10.
  - 101010 JMP: 0000, imm, br 11, single.
- Any other opcode decodes as a bubble with `illegal`=1.
- SWP (111111), two steps:
  - Step 0: exec_cmd 1100, swp_sel 01, wb_en 1, freeze 1.
  - Step 1: exec_cmd 1101, swp_sel 10, wb_en 1, freeze 0.
- MUL (001101), MUL_CYCLES steps:
  - exec_cmd 1011 on every step.
  - wb_en is 1 on the last step only.
  - freeze is 1 on every step except the last.
- FSM states IDLE and SEQ.
  - IDLE, with `valid`, `!stall` and `!flush`: decode the opcode. SWP or MUL emits step 0, latches the opcode, and moves to SEQ with `step`=1.
  - IDLE, with `!valid`: bubble.
  - SEQ, not stalled: emit the step for the latched opcode and increment `step`. On the last step, clear `freeze`, return to IDLE, and reset `step` to 0.
  - The live `opcode` is ignored while in SEQ.
- `stall`: bubble; state, `step`, latched opcode and `freeze` are all held.
- `flush`: bubble, force IDLE, `step`=0, `freeze`=0. `flush` has priority over `stall` and over decode.

## Timing
- All outputs are registered. Controls for the opcode sampled at edge k are valid after edge k.
- `freeze` rises with step 0 and falls with the final step, so upstream releases ID one edge after the last micro-op.
- Latency of a sequence with no stalls: SWP occupies 2 cycles, MUL occupies MUL_CYCLES cycles.
- A new instruction is decoded at the edge after the final step.
- `rst` asynchronously clears all outputs, the state (to IDLE), `step` and the latched opcode. This applies mid-sequence too: SWP or MUL is abandoned with no further `wb_en`.
- `stall` and `flush` are sampled at each edge. A stall during the last step delays it by the stall length.

## Test plan
- Reset, then ADD with valid: next cycle exec_cmd=0000, wb_en=1, freeze=0, busy=0. Then LD: mem_r_en=1, is_imm=1, single_src=1, wb_en=1.
- SWP: cycle 1 gives exec_cmd 1100, swp_sel 01, wb 1, freeze 1. Cycle 2 gives 1101, swp_sel 10, wb 1, freeze 0. Cycle 3 decodes the next opcode.
- MUL with MUL_CYCLES=4: exec_cmd 1011 for 4 cycles; wb_en only in cycle 4; freeze 1,1,1,0; step 0,1,2,3.
- MUL with 2 stall cycles after step 1: two bubble cycles with freeze=1 and step held at 2; the sequence then resumes to completion (6 cycles total).
- Flush during SWP step 0, and a flush/stall tie: bubble, IDLE, freeze=0; SWP step 1 is never issued.
- Opcode 010101 gives a bubble with illegal=1 for one cycle. With OPCODE_W=8, opcode 0x41 is illegal. `rst` asserted mid-MUL clears all outputs immediately.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// Registered ID-stage control decoder that also sequences SWP (2 steps) and MUL (MUL_CYCLES steps).
// Controls appear one edge after the opcode is sampled; stall emits a bubble and holds the sequence, flush kills it.
module ctrl_sequencer #(
   parameter  int OPCODE_W   = 6,
   parameter  int CMD_W      = 4,
   parameter  int MUL_CYCLES = 4,
   localparam int STEP_W     = $clog2((MUL_CYCLES < 2) ? 2 : MUL_CYCLES)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                valid,
   input  logic                stall,
   input  logic                flush,
   output logic [CMD_W-1:0]    exec_cmd,
   output logic                mem_r_en,
   output logic                mem_w_en,
   output logic                wb_en,
   output logic                is_imm,
   output logic                single_src,
   output logic [1:0]          branch_type,
   output logic [1:0]          swp_sel,
   output logic                freeze,
   output logic                busy,
   output logic [STEP_W-1:0]   step,
   output logic                illegal
);

   typedef enum logic {IDLE = 1'b0, SEQ = 1'b1} state_t;

   localparam logic [5:0]        OP_SWP   = 6'b111111;
   localparam logic [5:0]        OP_MUL   = 6'b001101;
   localparam logic [STEP_W-1:0] SWP_LAST = STEP_W'(1);
   localparam logic [STEP_W-1:0] MUL_LAST = STEP_W'(MUL_CYCLES - 1);

   state_t            state_q, state_d;
   logic [STEP_W-1:0] cnt_q, cnt_d;
   logic              mul_q, mul_d;

   logic [3:0]        cmd_q, cmd_d;
   logic              mr_q, mr_d, mw_q, mw_d, wb_q, wb_d;
   logic              imm_q, imm_d, sgl_q, sgl_d, ill_q, ill_d;
   logic [1:0]        br_q, br_d, swp_q, swp_d;
   logic [STEP_W-1:0] step_q, step_d;

   logic [5:0]        op6;
   logic              hi_zero;
   logic [3:0]        dec_cmd;
   logic              dec_wb, dec_imm, dec_mr, dec_mw, dec_sgl, dec_ill, dec_seq;
   logic [1:0]        dec_br;

   logic              uop_mul, uop_wb, uop_last;
   logic [STEP_W-1:0] uop_idx;
   logic [3:0]        uop_cmd;
   logic [1:0]        uop_swp;

   assign op6     = opcode[5:0];
   assign hi_zero = ((opcode >> 6) == '0);

   always_comb begin
      dec_cmd = 4'b0000;
      dec_wb  = 1'b0;
      dec_imm = 1'b0;
      dec_mr  = 1'b0;
      dec_mw  = 1'b0;
      dec_sgl = 1'b0;
      dec_br  = 2'b00;
      dec_ill = 1'b0;
      dec_seq = 1'b0;
      if (!hi_zero) begin
         dec_ill = 1'b1;
      end else begin
         case (op6)
            6'b000000: ;
            6'b000001: dec_wb = 1'b1;
            6'b000011: begin dec_cmd = 4'b0010; dec_wb = 1'b1; end
            6'b000101: begin dec_cmd = 4'b0100; dec_wb = 1'b1; end
            6'b000110: begin dec_cmd = 4'b0101; dec_wb = 1'b1; end
            6'b000111: begin dec_cmd = 4'b0110; dec_wb = 1'b1; end
            6'b001000: begin dec_cmd = 4'b0111; dec_wb = 1'b1; end
            6'b001001,
            6'b001010: begin dec_cmd = 4'b1000; dec_wb = 1'b1; end
            6'b001011: begin dec_cmd = 4'b1001; dec_wb = 1'b1; end
            6'b001100: begin dec_cmd = 4'b1010; dec_wb = 1'b1; end
            6'b100000: begin dec_imm = 1'b1; dec_wb = 1'b1; dec_sgl = 1'b1; end
            6'b100001: begin dec_cmd = 4'b0010; dec_imm = 1'b1; dec_wb = 1'b1; dec_sgl = 1'b1; end
            6'b100100: begin dec_imm = 1'b1; dec_mr = 1'b1; dec_wb = 1'b1; dec_sgl = 1'b1; end
            6'b100101: begin dec_imm = 1'b1; dec_mw = 1'b1; end
            6'b101000: begin dec_imm = 1'b1; dec_br = 2'b01; dec_sgl = 1'b1; end
            6'b101001: begin dec_imm = 1'b1; dec_br = 2'b10; end
            6'b101010: begin dec_imm = 1'b1; dec_br = 2'b11; dec_sgl = 1'b1; end
            OP_SWP,
            OP_MUL:    dec_seq = 1'b1;
            default:   dec_ill = 1'b1;
         endcase
      end
   end

   // Step 0 is issued from IDLE using the live opcode; later steps use the latched kind and counter.
   assign uop_mul = (state_q == SEQ) ? mul_q : (op6 == OP_MUL);
   assign uop_idx = (state_q == SEQ) ? cnt_q : '0;

   always_comb begin
      uop_cmd  = 4'b0000;
      uop_swp  = 2'b00;
      uop_wb   = 1'b0;
      uop_last = 1'b0;
      if (uop_mul) begin
         uop_cmd  = 4'b1011;
         uop_last = (uop_idx == MUL_LAST);
         uop_wb   = uop_last;
      end else begin
         uop_last = (uop_idx == SWP_LAST);
         uop_cmd  = uop_last ? 4'b1101 : 4'b1100;
         uop_swp  = uop_last ? 2'b10 : 2'b01;
         uop_wb   = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mul_d   = mul_q;
      cmd_d   = 4'b0000;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      wb_d    = 1'b0;
      imm_d   = 1'b0;
      sgl_d   = 1'b0;
      br_d    = 2'b00;
      swp_d   = 2'b00;
      ill_d   = 1'b0;
      step_d  = '0;
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (stall) begin
         step_d = cnt_q;
      end else if (state_q == SEQ) begin
         cmd_d  = uop_cmd;
         swp_d  = uop_swp;
         wb_d   = uop_wb;
         step_d = cnt_q;
         if (uop_last) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (valid) begin
         if (dec_seq) begin
            cmd_d   = uop_cmd;
            swp_d   = uop_swp;
            wb_d    = uop_wb;
            mul_d   = uop_mul;
            state_d = SEQ;
            cnt_d   = STEP_W'(1);
         end else begin
            cmd_d = dec_cmd;
            mr_d  = dec_mr;
            mw_d  = dec_mw;
            wb_d  = dec_wb;
            imm_d = dec_imm;
            sgl_d = dec_sgl;
            br_d  = dec_br;
            ill_d = dec_ill;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mul_q   <= 1'b0;
         cmd_q   <= 4'b0000;
         mr_q    <= 1'b0;
         mw_q    <= 1'b0;
         wb_q    <= 1'b0;
         imm_q   <= 1'b0;
         sgl_q   <= 1'b0;
         br_q    <= 2'b00;
         swp_q   <= 2'b00;
         ill_q   <= 1'b0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mul_q   <= mul_d;
         cmd_q   <= cmd_d;
         mr_q    <= mr_d;
         mw_q    <= mw_d;
         wb_q    <= wb_d;
         imm_q   <= imm_d;
         sgl_q   <= sgl_d;
         br_q    <= br_d;
         swp_q   <= swp_d;
         ill_q   <= ill_d;
         step_q  <= step_d;
      end
   end

   assign exec_cmd    = CMD_W'(cmd_q);
   assign mem_r_en    = mr_q;
   assign mem_w_en    = mw_q;
   assign wb_en       = wb_q;
   assign is_imm      = imm_q;
   assign single_src  = sgl_q;
   assign branch_type = br_q;
   assign swp_sel     = swp_q;
   // The sequence holds ID exactly while further micro-ops are pending, which is the SEQ state.
   assign freeze      = (state_q == SEQ);
   assign busy        = (state_q == SEQ);
   assign step        = step_q;
   assign illegal     = ill_q;

endmodule
